// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch-side initiator for the word-addressed instruction memory of the RV32I
// core. It owns the program counter, issues at most one read per cycle to a
// memory with a one-cycle registered read, and presents {instr, pc} to decode
// through a valid/ready handshake. Execute-stage redirects (taken branches and
// jumps) squash whatever is currently presented and restart fetch at the
// target. Misaligned redirect targets, and fetches that run past the end of
// memory, park the unit in a sticky FAULT state until a legal redirect arrives.
//
// Parameters
//   RESET_PC   first PC fetched after reset
//   MEM_DEPTH  instruction memory size in 32-bit words; legal addr < MEM_DEPTH*4
//
// Ports
//   clk                  in   1   rising-edge clock
//   reset                in   1   asynchronous, active-high reset
//   instr_mem_req_o      out  1   read request to instruction memory
//   instr_mem_addr_o     out  32  byte address (memory uses [31:2]); 0 when idle
//   instr_mem_rd_data_i  in   32  read data, valid the cycle after a request,
//                                 held by the memory while no request is made
//   redirect_i           in   1   branch/jump taken; squashes presented instr
//   redirect_pc_i        in   32  redirect target byte address
//   if_valid_o           out  1   instruction/pc valid to decode
//   if_ready_i           in   1   decode accepts when valid && ready
//   if_instr_o           out  32  instruction presented to decode
//   if_pc_o              out  32  byte address of if_instr_o
//   fetch_fault_o        out  1   sticky fetch fault
//   fetch_count_o        out  32  number of accepted instructions (wraps)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH = 496
) (
    input  logic        clk,
    input  logic        reset,
    output logic        instr_mem_req_o,
    output logic [31:0] instr_mem_addr_o,
    input  logic [31:0] instr_mem_rd_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic        fetch_fault_o,
    output logic [31:0] fetch_count_o
);

    // First byte address past the end of instruction memory.
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_DEPTH * 4);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        pending_q, pending_d;
    logic [31:0] count_q;

    logic        redirect_legal;
    logic        pc_in_range;
    logic        fire;
    logic        valid;
    logic        accept;
    logic        req;
    logic [31:0] addr;

    // Qualifiers used by the next-state logic. Range compares are unsigned,
    // so a wrapped PC near 2^32 is correctly seen as out of range.
    always_comb begin
        redirect_legal = (redirect_pc_i[1:0] == 2'b00) && (redirect_pc_i < MEM_LIMIT);
        pc_in_range    = (pc_q < MEM_LIMIT);
        // A new read may only be issued when the slot it will land in is
        // free, either because nothing is pending or because decode is taking
        // the pending item this very cycle.
        fire           = !pending_q || if_ready_i;
        // A redirect squashes the presented instruction in the same cycle, so
        // any handshake that coincides with it is not a real acceptance.
        valid          = pending_q && !redirect_i && (state_q != BOOT);
        accept         = valid && if_ready_i;
    end

    // State register: FSM state, fetch PC, PC of the word in flight and the
    // flag saying the memory output holds an instruction not yet accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            inflight_pc_q <= 32'h0;
            pending_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            pending_q     <= pending_d;
        end
    end

    // Next-state and memory request logic. Everything holds by default, which
    // is exactly the stall behaviour: with no request the memory keeps its
    // read data, so the presented instr/pc stay stable without extra storage.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        pending_d     = pending_q;
        req           = 1'b0;
        addr          = 32'h0;

        unique case (state_q)
            BOOT: begin
                // One idle cycle after reset release before the first read.
                state_d = RUN;
            end

            RUN: begin
                if (redirect_i) begin
                    if (redirect_legal) begin
                        req           = 1'b1;
                        addr          = redirect_pc_i;
                        pending_d     = 1'b1;
                        inflight_pc_d = redirect_pc_i;
                        pc_d          = redirect_pc_i + 32'd4;
                    end else begin
                        pending_d = 1'b0;
                        state_d   = FAULT;
                    end
                end else if (fire) begin
                    if (pc_in_range) begin
                        req           = 1'b1;
                        addr          = pc_q;
                        pending_d     = 1'b1;
                        inflight_pc_d = pc_q;
                        pc_d          = pc_q + 32'd4;
                    end else begin
                        // fire implies the pending item (if any) is being
                        // accepted now, so the slot empties as we fault.
                        pending_d = 1'b0;
                        state_d   = FAULT;
                    end
                end
            end

            FAULT: begin
                if (redirect_i) begin
                    if (redirect_legal) begin
                        req           = 1'b1;
                        addr          = redirect_pc_i;
                        pending_d     = 1'b1;
                        inflight_pc_d = redirect_pc_i;
                        pc_d          = redirect_pc_i + 32'd4;
                        state_d       = RUN;
                    end else begin
                        pending_d = 1'b0;
                    end
                end else if (accept) begin
                    // A leftover instruction is still delivered while faulted.
                    pending_d = 1'b0;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Accepted-instruction counter, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 32'h0;
        end else if (accept) begin
            count_q <= count_q + 32'd1;
        end
    end

    // Output drive.
    always_comb begin
        instr_mem_req_o  = req;
        instr_mem_addr_o = addr;
        if_valid_o       = valid;
        if_instr_o       = instr_mem_rd_data_i;
        if_pc_o          = inflight_pc_q;
        fetch_fault_o    = (state_q == FAULT);
        fetch_count_o    = count_q;
    end

endmodule
